// File: rtl/jtopl_timer_pkg.sv
// Shared constants and helpers for the jtopl timer bank.
// OPL defaults: two channels, 8-bit counters, 2/4-bit prescalers.
package jtopl_timer_pkg;

   localparam int OPL_NCH     = 2;
   localparam int OPL_CW      = 8;
   localparam int OPL_PW_BASE = 2;
   localparam int OPL_PW_STEP = 2;

   function automatic int pw_of(
      input int i,
      input int base = OPL_PW_BASE,
      input int step = OPL_PW_STEP
   );
      return base + i * step;
   endfunction

endpackage

// File: rtl/jtopl_timer_bank_if.sv
// Register-side bundle of the timer bank.
// Master drives controls, slave returns status.
interface jtopl_timer_bank_if #(
   parameter int NCH = 2,
   parameter int CW  = 8
);
   logic              cenop;
   logic              zero;
   logic [NCH*CW-1:0] value;
   logic [NCH-1:0]    load;
   logic [NCH-1:0]    oneshot;
   logic [NCH-1:0]    clr_flag;
   logic [NCH-1:0]    flagen;
   logic [NCH-1:0]    flag;
   logic [NCH-1:0]    overflow;
   logic [NCH*CW-1:0] cnt;
   logic              irq_n;

   modport master (
      output cenop, zero, value, load, oneshot,
      output clr_flag, flagen,
      input  flag, overflow, cnt, irq_n
   );

   modport slave (
      input  cenop, zero, value, load, oneshot,
      input  clr_flag, flagen,
      output flag, overflow, cnt, irq_n
   );
endinterface

// File: rtl/jtopl_timer_ch.sv
// One timer channel: prescaler, reloadable counter, flag.
// One-shot stop logic exists only with JTOPL_TIMER_ONESHOT_EN.
module jtopl_timer_ch #(
   parameter int PW = 2,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick_i,
   input  logic [CW-1:0] value_i,
   input  logic          load_i,
   input  logic          oneshot_i,
   input  logic          clr_flag_i,
   input  logic          flagen_i,
   output logic          flag_o,
   output logic          overflow_o,
   output logic [CW-1:0] cnt_o
);

   localparam logic [PW-1:0] P_ONE = PW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_l_q;
   logic          pflag_q, pflag_d;
   logic          ovf_q, ovf_d;
   logic          stopped;
   logic          carry, ledge, run, wrap;

   assign carry = tick_i & (&pre_q);
   assign ledge = load_i & ~load_l_q;
   assign run   = load_i & ~stopped & carry;
   assign wrap  = &cnt_q;

   always_comb begin
      pre_d   = tick_i ? pre_q + P_ONE : pre_q;
      ovf_d   = ~ledge & run & wrap;
      cnt_d   = cnt_q;
      if (ledge)
         cnt_d = value_i;
      else if (run)
         cnt_d = wrap ? value_i : cnt_q + C_ONE;
      pflag_d = pflag_q;
      if (clr_flag_i)
         pflag_d = 1'b0;
      else if (ovf_d)
         pflag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q    <= '0;
         cnt_q    <= '0;
         load_l_q <= 1'b0;
         pflag_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         load_l_q <= load_i;
         pflag_q  <= pflag_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef JTOPL_TIMER_ONESHOT_EN
   logic stop_q, stop_d;

   always_comb begin
      stop_d = stop_q;
      if (ledge)
         stop_d = 1'b0;
      else if (ovf_d & oneshot_i)
         stop_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stop_q <= 1'b0;
      else
         stop_q <= stop_d;
   end

   assign stopped = stop_q;
`else
   logic unused_oneshot;
   assign unused_oneshot = oneshot_i;
   assign stopped = 1'b0;
`endif

   assign flag_o     = pflag_q & flagen_i;
   assign overflow_o = ovf_q;
   assign cnt_o      = cnt_q;

endmodule

// File: rtl/jtopl_timer_bank.sv
// N-channel timer bank with combined active-low IRQ.
// Optional one-shot mode: define JTOPL_TIMER_ONESHOT_EN.
module jtopl_timer_bank
   import jtopl_timer_pkg::*;
#(
   parameter int NCH     = OPL_NCH,
   parameter int CW      = OPL_CW,
   parameter int PW_BASE = OPL_PW_BASE,
   parameter int PW_STEP = OPL_PW_STEP
) (
   input  logic         clk,
   input  logic         rst_n,
   jtopl_timer_bank_if.slave bus
);

   logic tick;

   assign tick = bus.cenop & bus.zero;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam int PW = pw_of(i, PW_BASE, PW_STEP);

      jtopl_timer_ch #(
         .PW (PW),
         .CW (CW)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick_i     (tick),
         .value_i    (bus.value[i*CW +: CW]),
         .load_i     (bus.load[i]),
         .oneshot_i  (bus.oneshot[i]),
         .clr_flag_i (bus.clr_flag[i]),
         .flagen_i   (bus.flagen[i]),
         .flag_o     (bus.flag[i]),
         .overflow_o (bus.overflow[i]),
         .cnt_o      (bus.cnt[i*CW +: CW])
      );
   end

   assign bus.irq_n = ~|bus.flag;

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// Scoreboard bench for jtopl_timer_bank (OPL defaults).
// Overflow ticks are queued by stimulus and popped by a monitor.
module tb_jtopl_timer_bank;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   tick_no;
   int   q0[$];
   int   q1[$];

   jtopl_timer_bank_if #(.NCH(2), .CW(8)) bus ();

   jtopl_timer_bank #(
      .NCH     (2),
      .CW      (8),
      .PW_BASE (2),
      .PW_STEP (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (tick %0d)",
                  name, got, exp, tick_no);
      end
   endtask

   task automatic step(input bit t);
      bus.cenop = 1'b1;
      bus.zero  = t;
      @(posedge clk);
      #1;
      if (t) tick_no++;
      bus.cenop = 1'b0;
      bus.zero  = 1'b0;
   endtask

   task automatic run(input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         step(1'b1);
         for (int g = 0; g < gap; g++) step(1'b0);
      end
   endtask

   // Monitor: each overflow pulse must match the next queued tick
   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (bus.overflow[ch]) begin
            if (ch == 0 && q0.size() > 0)
               chk("ovf0_tick", tick_no, q0.pop_front());
            else if (ch == 1 && q1.size() > 0)
               chk("ovf1_tick", tick_no, q1.pop_front());
            else begin
               tests++;
               fails++;
               $display("FAIL ovf%0d_unexpected: pulse at tick %0d, none expected",
                        ch, tick_no);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      tests = 0; fails = 0; tick_no = 0;
      rst_n = 1'b0;
      bus.cenop = 0; bus.zero = 0; bus.value = '0; bus.load = '0;
      bus.oneshot = '0; bus.clr_flag = '0; bus.flagen = '0;
      #2;
      chk("rst_flag", bus.flag, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_cnt", bus.cnt, 0);
      chk("rst_irq", bus.irq_n, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Periodic reload, ch0 FE, one tick per 4 clks
      bus.value[7:0] = 8'hFE;
      bus.load = 2'b01;
      bus.flagen = 2'b01;
      step(1'b0);
      chk("t1_load_cnt", bus.cnt[7:0], 8'hFE);
      q0.push_back(8); q0.push_back(16); q0.push_back(24);
      run(3, 3);
      chk("t1_cnt_t3", bus.cnt[7:0], 8'hFE);
      run(1, 3);
      chk("t1_cnt_t4", bus.cnt[7:0], 8'hFF);
      run(4, 3);
      chk("t1_cnt_t8", bus.cnt[7:0], 8'hFE);
      chk("t1_flag", bus.flag, 2'b01);
      chk("t1_irq", bus.irq_n, 0);
      run(16, 3);
      bus.load = 2'b00;
      step(1'b0);
      chk("t1_hold", bus.cnt[7:0], 8'hFE);

      // ch1 prescaler independence and masking
      bus.clr_flag = 2'b01;
      bus.value[15:8] = 8'hFF;
      bus.load = 2'b10;
      step(1'b0);
      bus.clr_flag = 2'b00;
      chk("t2_flag_clr", bus.flag, 0);
      chk("t2_irq_clr", bus.irq_n, 1);
      chk("t2_load_cnt", bus.cnt[15:8], 8'hFF);
      q1.push_back(32); q1.push_back(48);
      run(8, 0);
      chk("t2_masked_flag", bus.flag, 0);
      chk("t2_masked_irq", bus.irq_n, 1);
      bus.flagen = 2'b11;
      #1;
      chk("t2_unmask_flag", bus.flag, 2'b10);
      chk("t2_unmask_irq", bus.irq_n, 0);
      bus.clr_flag = 2'b10;
      step(1'b0);
      bus.clr_flag = 2'b00;
      chk("t2_clr1_flag", bus.flag, 0);
      chk("t2_clr1_irq", bus.irq_n, 1);
      run(16, 0);
      bus.value[15:8] = 8'hFE;
      run(8, 0);
      chk("t2_val_no_effect", bus.cnt[15:8], 8'hFF);
      bus.load = 2'b00;
      step(1'b0);
      chk("t2_load_low_hold", bus.cnt[15:8], 8'hFF);
      bus.load = 2'b10;
      step(1'b0);
      chk("t2_reload", bus.cnt[15:8], 8'hFE);
      q1.push_back(80);
      run(8, 0);
      chk("t2_cnt_t64", bus.cnt[15:8], 8'hFF);
      run(16, 0);
      chk("t2_cnt_t80", bus.cnt[15:8], 8'hFE);
      bus.load = 2'b00;

      // Clear vs set collision on ch0
      bus.value[7:0] = 8'hFF;
      bus.load = 2'b01;
      bus.clr_flag = 2'b10;
      step(1'b0);
      bus.clr_flag = 2'b00;
      chk("t3_cnt", bus.cnt[7:0], 8'hFF);
      chk("t3_flag0", bus.flag, 0);
      q0.push_back(84);
      run(3, 0);
      bus.clr_flag = 2'b01;
      step(1'b1);
      bus.clr_flag = 2'b00;
      chk("t3_coll_ovf", bus.overflow, 2'b01);
      chk("t3_coll_flag", bus.flag, 0);
      chk("t3_coll_irq", bus.irq_n, 1);
      q0.push_back(88);
      run(4, 0);
      chk("t3_set_flag", bus.flag, 2'b01);
      chk("t3_set_irq", bus.irq_n, 0);
      bus.clr_flag = 2'b01;
      step(1'b0);
      bus.clr_flag = 2'b00;
      chk("t3_late_clr_flag", bus.flag, 0);
      chk("t3_late_clr_irq", bus.irq_n, 1);
      bus.load = 2'b00;
      step(1'b0);

      // One-shot on ch0
      bus.oneshot = 2'b01;
      bus.load = 2'b01;
      step(1'b0);
      q0.push_back(92);
`ifndef JTOPL_TIMER_ONESHOT_EN
      q0.push_back(96); q0.push_back(100);
`endif
      run(12, 0);
      chk("t4_cnt_frozen", bus.cnt[7:0], 8'hFF);
      bus.load = 2'b00;
      step(1'b0);
      bus.load = 2'b01;
      step(1'b0);
      q0.push_back(104);
      run(4, 0);
      chk("t4_restart_flag", bus.flag, 2'b01);

      // Async reset during an overflow pulse
      bus.oneshot = 2'b00;
      bus.load = 2'b00;
      step(1'b0);
      bus.load = 2'b01;
      step(1'b0);
      run(3, 0);
      step(1'b1);
      chk("t5_pre_ovf", bus.overflow, 2'b01);
      chk("t5_pre_irq", bus.irq_n, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_flag", bus.flag, 0);
      chk("t5_rst_ovf", bus.overflow, 0);
      chk("t5_rst_cnt", bus.cnt, 0);
      chk("t5_rst_irq", bus.irq_n, 1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
